// File: rtl/cache_main_memory.sv
// Block-granular main memory behind the data cache: whole-block refills and write-backs.
// Latency: request edge + LATENCY wait cycles + WORDS_PER_BLOCK burst beats, then a 1-cycle mem_ready.
// Backpressure: none; requests are only sampled in IDLE and ignored while busy.
module cache_main_memory #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int MEM_DEPTH       = 1024,
  parameter int LATENCY         = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  rd_mem,
  input  logic                                  wr_mem,
  input  logic [ADDR_WIDTH-1:0]                 addr,
  input  logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] wr_block,
  output logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] rd_block,
  output logic                                  mem_ready,
  output logic                                  busy
);

  localparam int BYTE_OFF = $clog2(DATA_WIDTH / 8);
  localparam int BEAT_W   = $clog2(WORDS_PER_BLOCK);
  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam int BLKN_W   = IDX_W - BEAT_W;
  localparam int LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int BLK_W    = DATA_WIDTH * WORDS_PER_BLOCK;

  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

  state_t                state;
  logic [LAT_W-1:0]      lat_cnt;
  logic [BEAT_W-1:0]     beat;
  logic                  is_wr;
  logic [BLKN_W-1:0]     blk_num;   // block number within the array; wraps mod MEM_DEPTH
  logic [BLK_W-1:0]      wr_lat;    // write-back data captured at request time
  logic [BLK_W-1:0]      rd_buf;    // refill data assembled beat by beat
  logic [BLK_W-1:0]      buf_next;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] mem_rd_word;
  logic [DATA_WIDTH-1:0] wr_word;
  logic                  last_beat;
  logic                  unused_addr;

  // Block base has its low beat bits cleared, so base+beat never carries: concatenation is the sum.
  assign mem_idx     = {blk_num, beat};
  assign mem_rd_word = mem[mem_idx];
  assign wr_word     = wr_lat[int'(beat)*DATA_WIDTH +: DATA_WIDTH];
  assign last_beat   = (beat == BEAT_W'(WORDS_PER_BLOCK - 1));
  // Byte-offset and out-of-range high address bits carry no information here.
  assign unused_addr = ^addr;

  // Refill buffer with the current beat's word merged in, so DONE sees the complete block.
  always_comb begin
    buf_next = rd_buf;
    buf_next[int'(beat)*DATA_WIDTH +: DATA_WIDTH] = mem_rd_word;
  end

  // Transaction FSM with registered mem_ready/busy/rd_block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      rd_block  <= '0;
      lat_cnt   <= '0;
      beat      <= '0;
      is_wr     <= 1'b0;
      blk_num   <= '0;
      wr_lat    <= '0;
      rd_buf    <= '0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_mem || wr_mem) begin
            // A simultaneous read is dropped; the write wins and the cache reissues the read.
            is_wr   <= wr_mem;
            blk_num <= addr[BYTE_OFF+BEAT_W +: BLKN_W];
            wr_lat  <= wr_block;
            lat_cnt <= LAT_W'(LATENCY - 1);
            state   <= WAIT;
            busy    <= 1'b1;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            state <= XFER;
            beat  <= '0;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        XFER: begin
          if (!is_wr) begin
            rd_buf <= buf_next;
          end
          if (last_beat) begin
            state     <= DONE;
            mem_ready <= 1'b1;
            if (!is_wr) begin
              rd_block <= buf_next;
            end
          end else begin
            beat <= beat + BEAT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage: one synchronous write per XFER beat; contents survive reset.
  always_ff @(posedge clk) begin
    if (state == XFER && is_wr) begin
      mem[mem_idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_cache_main_memory.sv
// Directed bench for cache_main_memory with default parameters.
// Drives and samples on the falling clock edge; latency counted in rising edges after the sampling edge.
// Requests are held until mem_ready is seen, then dropped.
module tb_cache_main_memory;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int WPB = 4;
  localparam int MD  = 1024;
  localparam int LAT = 4;
  localparam int BW  = DW * WPB;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_mem;
  logic          wr_mem;
  logic [AW-1:0] addr;
  logic [BW-1:0] wr_block;
  logic [BW-1:0] rd_block;
  logic          mem_ready;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_main_memory #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_BLOCK(WPB),
    .MEM_DEPTH(MD), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .rd_mem(rd_mem), .wr_mem(wr_mem), .addr(addr),
    .wr_block(wr_block), .rd_block(rd_block), .mem_ready(mem_ready), .busy(busy)
  );

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] blk4(input logic [DW-1:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  // Issue a request, hold it until mem_ready, return the edge count (0 on timeout).
  task automatic run_req(input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [BW-1:0] d, output int edges);
    edges = 0;
    @(negedge clk);
    rd_mem = r; wr_mem = w; addr = a; wr_block = d;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (mem_ready) begin
        edges = n;
        break;
      end
    end
    rd_mem = 1'b0; wr_mem = 1'b0;
  endtask

  // The cycle after DONE must be IDLE with mem_ready already gone.
  task automatic after_done(input string tag);
    @(negedge clk);
    chk({tag, "_pulse_w"}, mem_ready, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   e;
    logic seen;
    rst = 1'b0; rd_mem = 1'b0; wr_mem = 1'b0; addr = '0; wr_block = '0;

    // Reset held 3 cycles, then 20 idle cycles.
    repeat (3) begin
      @(negedge clk);
      chk("rst_outs", {mem_ready, busy, rd_block}, 0);
    end
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("idle_outs", {mem_ready, busy, rd_block}, 0);
    end

    // Write then read with defaults.
    run_req(1'b0, 1'b1, 32'h40, blk4(32'h11, 32'h22, 32'h33, 32'h44), e);
    chk("wr_lat", e, 9);
    chk("wr_rdblk", rd_block, 0);
    after_done("wr");
    run_req(1'b1, 1'b0, 32'h4C, '0, e);
    chk("rd_lat", e, 9);
    chk("rd_data", rd_block, blk4(32'h11, 32'h22, 32'h33, 32'h44));
    after_done("rd");
    chk("rd_hold", rd_block, blk4(32'h11, 32'h22, 32'h33, 32'h44));

    // Simultaneous read and write: write wins.
    run_req(1'b1, 1'b1, 32'h80, blk4(32'hA, 32'hB, 32'hC, 32'hD), e);
    chk("both_lat", e, 9);
    chk("both_rdblk", rd_block, blk4(32'h11, 32'h22, 32'h33, 32'h44));
    after_done("both");
    run_req(1'b1, 1'b0, 32'h80, '0, e);
    chk("both_rd_lat", e, 9);
    chk("both_rd_data", rd_block, blk4(32'hA, 32'hB, 32'hC, 32'hD));

    // Address wrap-around, plus a block used later by the busy-input test.
    run_req(1'b0, 1'b1, MD * 4 + 32'h10, blk4(32'h1, 32'h2, 32'h3, 32'h4), e);
    chk("wrap_wr_lat", e, 9);
    run_req(1'b0, 1'b1, 32'h200, blk4(32'h21, 32'h22, 32'h23, 32'h24), e);
    chk("pre_wr_lat", e, 9);
    run_req(1'b1, 1'b0, 32'h10, '0, e);
    chk("wrap_rd_lat", e, 9);
    chk("wrap_rd_data", rd_block, blk4(32'h1, 32'h2, 32'h3, 32'h4));

    // Reset during XFER beat 2 of a read.
    @(negedge clk);
    rd_mem = 1'b1; addr = 32'h80;
    @(posedge clk);
    repeat (7) @(negedge clk);
    chk("mid_busy", busy, 1);
    rd_mem = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", mem_ready, 0);
    chk("mid_rst_rdblk", rd_block, 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (mem_ready) seen = 1'b1;
    end
    chk("mid_no_ready", seen, 0);
    run_req(1'b1, 1'b0, 32'h40, '0, e);
    chk("post_rst_lat", e, 9);
    chk("post_rst_data", rd_block, blk4(32'h11, 32'h22, 32'h33, 32'h44));

    // Inputs changed while busy: latched block is written, re-asserted read ignored.
    @(negedge clk);
    wr_mem = 1'b1; addr = 32'h100; wr_block = blk4(32'h5, 32'h6, 32'h7, 32'h8);
    @(posedge clk);
    e = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 2) begin
        addr = 32'h200; wr_block = blk4(32'h9, 32'h9, 32'h9, 32'h9);
      end
      if (n == 5) begin
        wr_mem = 1'b0; rd_mem = 1'b1; addr = 32'h200;
      end
      if (mem_ready) begin
        e = n;
        break;
      end
    end
    rd_mem = 1'b0; wr_mem = 1'b0;
    chk("chg_lat", e, 9);
    chk("chg_rdblk", rd_block, blk4(32'h11, 32'h22, 32'h33, 32'h44));
    after_done("chg");
    run_req(1'b1, 1'b0, 32'h100, '0, e);
    chk("chg_rd_lat", e, 9);
    chk("chg_rd_data", rd_block, blk4(32'h5, 32'h6, 32'h7, 32'h8));
    run_req(1'b1, 1'b0, 32'h200, '0, e);
    chk("chg_other_data", rd_block, blk4(32'h21, 32'h22, 32'h23, 32'h24));
    after_done("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
